// File: rtl/fifo_burst_drain_pkg.sv
// fifo_burst_drain_pkg
//   Shared definitions for the burst drain stage: FSM state encoding and the
//   width helper used to size the burst-length fields.
package fifo_burst_drain_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    // Bits needed to hold a word count in 0..burst_len.
    function automatic int len_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/burst_timeout_timer.sv
// burst_timeout_timer
//   Idle timer for the burst drain stage. Counts cycles in which a partial
//   burst sits waiting, saturating at TIMEOUT-1.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   clear   - forces the count back to zero (wins over counting)
//   enable  - counting permitted (drain FSM idle)
//   count   - a count request this cycle (FIFO holds data)
//   expired - count has reached TIMEOUT-1; constant 0 when TIMEOUT == 0
module burst_timeout_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic count,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && count && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain
//   Read-side drain for a fall-through sync FIFO. Pops words and forwards them
//   on a valid/ready stream as bursts of at most BURST_LEN words, with a last
//   marker and a length field. A burst starts when a full burst is buffered,
//   when the idle timer expires on a partial burst, or on flush_i.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   fifo_data_i      - FIFO head word (fall-through)
//   fifo_empty_i     - FIFO empty
//   fifo_counter_i   - FIFO occupancy
//   fifo_rd_valid_o  - pop strobe to the FIFO
//   flush_i          - level request to emit whatever is buffered
//   m_data_o         - output word (registered)
//   m_valid_o        - output valid
//   m_ready_i        - downstream ready
//   m_last_o         - final beat of a burst
//   m_len_o          - burst length minus one, stable across the burst
//   busy_o           - high while a burst is in progress
module fifo_burst_drain
    import fifo_burst_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 64,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int LEN_W      = len_width(BURST_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_WIDTH:0]   fifo_counter_i,
    output logic                  fifo_rd_valid_o,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic [LEN_W-1:0]      m_len_o,
    output logic                  busy_o
);

    localparam logic [31:0]      BURST_LEN_U = 32'(BURST_LEN);
    localparam logic [LEN_W-1:0] ONE         = LEN_W'(1);

    drain_state_t     state;
    logic [LEN_W-1:0] pop_left;   // words still to pop in this burst
    logic [LEN_W-1:0] beat_left;  // beats still to be accepted downstream
    logic [LEN_W-1:0] start_len;
    logic             has_data;
    logic             full_avail;
    logic             expired;
    logic             start;
    logic             pop;
    logic             accept;

    assign has_data   = (fifo_counter_i != '0);
    assign full_avail = (32'(fifo_counter_i) >= BURST_LEN_U);
    assign start      = (state == IDLE) && (full_avail || (has_data && (flush_i || expired)));

    // When not full_avail the occupancy is below BURST_LEN, so it fits LEN_W.
    assign start_len  = full_avail ? LEN_W'(BURST_LEN) : LEN_W'(fifo_counter_i);

    // Pop only when the output register is free or being drained this cycle.
    assign pop    = (state == STREAM) && (pop_left != '0) && !fifo_empty_i &&
                    (!m_valid_o || m_ready_i);
    assign accept = m_valid_o && m_ready_i;

    assign fifo_rd_valid_o = pop;
    assign busy_o          = (state == STREAM);

    burst_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state == STREAM) || !has_data || start),
        .enable  (state == IDLE),
        .count   (has_data),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pop_left  <= '0;
            beat_left <= '0;
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            m_len_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pop_left  <= start_len;
                        beat_left <= start_len;
                        m_len_o   <= start_len - ONE;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (pop) begin
                        m_data_o  <= fifo_data_i;
                        m_valid_o <= 1'b1;
                        m_last_o  <= (pop_left == ONE);
                        pop_left  <= pop_left - ONE;
                    end else if (accept) begin
                        m_valid_o <= 1'b0;
                        m_last_o  <= 1'b0;
                    end
                    if (accept) begin
                        beat_left <= beat_left - ONE;
                        if (beat_left == ONE) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain
//   Self-checking bench: a queue-based FIFO model feeds the DUT, a scoreboard
//   checks word order, and a per-cycle reference predicts burst starts,
//   lengths, pops and backpressure behaviour from the burst rules.
module tb_fifo_burst_drain;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int BL    = 8;
    localparam int TO    = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int LW    = $clog2(BL + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_data_i = '0;
    logic          fifo_empty_i = 1'b1;
    logic [CW-1:0] fifo_counter_i = '0;
    logic          fifo_rd_valid_o;
    logic          flush_i = 1'b0;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b1;
    logic          m_last_o;
    logic [LW-1:0] m_len_o;
    logic          busy_o;

    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    int            rdy_mode = 0;

    always #5 clk = ~clk;

    fifo_burst_drain #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .BURST_LEN  (BL),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_data_i     (fifo_data_i),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_counter_i  (fifo_counter_i),
        .fifo_rd_valid_o (fifo_rd_valid_o),
        .flush_i         (flush_i),
        .m_data_o        (m_data_o),
        .m_valid_o       (m_valid_o),
        .m_ready_i       (m_ready_i),
        .m_last_o        (m_last_o),
        .m_len_o         (m_len_o),
        .busy_o          (busy_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- FIFO model (fall-through) ----------------
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            exp_q.delete();
        end else begin
            if (fifo_rd_valid_o && fq.size() > 0) void'(fq.pop_front());
            if (wr_en && fq.size() < DEPTH) begin
                fq.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
        end
        fifo_counter_i <= CW'(fq.size());
        fifo_empty_i   <= (fq.size() == 0);
        fifo_data_i    <= (fq.size() > 0) ? fq[0] : '0;
    end

    // ---------------- ready driver ----------------
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       m_ready_i = (ph == 0) || (ph == 3);
                2:       m_ready_i = 1'($urandom_range(0, 1));
                default: m_ready_i = 1'b1;
            endcase
            ph = (ph + 1) % 4;
        end
    end

    // ---------------- reference model + monitor ----------------
    int            cyc = 0, idle_run = 0, exp_len = 0, beats = 0, pops = 0;
    int            rise_cyc = 0, nz_cyc = 0, flush_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0;
    int            n_last = 0, acc_total = 0, pop_total = 0, stall_cnt = 0;
    int            p_c = 0;
    logic          p_f = 0, p_v = 0, p_rdy = 0, p_l = 0, p_b = 0, p_ok = 0, after_rst = 0, m_busy = 0;
    logic [DW-1:0] p_d = '0;
    logic [LW-1:0] p_len = '0;
    int            bursts[$];

    always @(negedge clk) begin
        int c;
        logic [DW-1:0] e;
        cyc++;
        c = int'(fifo_counter_i);
        if (rst) begin
            p_ok = 0; m_busy = 0; idle_run = 0; after_rst = 1;
        end else begin
            if (after_rst) begin
                chk("rst_busy",  busy_o, 0);
                chk("rst_valid", m_valid_o, 0);
                chk("rst_last",  m_last_o, 0);
                chk("rst_len",   m_len_o, 0);
                chk("rst_data",  m_data_o, 0);
                chk("rst_pop",   fifo_rd_valid_o, 0);
                after_rst = 0;
            end
            if (p_ok) begin
                if (!m_busy) begin
                    // A burst must start after a full burst is buffered, a
                    // flush, or TO consecutive idle cycles with data waiting.
                    if (p_c >= BL || (p_c != 0 && (p_f || (TO != 0 && idle_run == TO)))) begin
                        m_busy = 1; exp_len = (p_c < BL) ? p_c : BL; beats = 0; pops = 0;
                        chk("start_len", m_len_o, exp_len - 1);
                    end
                end else if (beats == exp_len) begin
                    m_busy = 0;
                    chk("burst_pops", pops, exp_len);
                end
                chk("busy", busy_o, m_busy);
                if (p_v && !p_rdy) begin
                    chk("hold_valid", m_valid_o, 1);
                    chk("hold_data",  m_data_o, p_d);
                    chk("hold_last",  m_last_o, p_l);
                    chk("hold_len",   m_len_o, p_len);
                end
                if (busy_o && !p_b) rise_cyc = cyc;
            end
            if (m_busy) chk("pop", fifo_rd_valid_o, (pops < exp_len) && (c != 0) && !(m_valid_o && !m_ready_i));
            else        chk("idle_pop", fifo_rd_valid_o, 0);
            if (fifo_rd_valid_o) begin pops++; pop_total++; end
            if (m_valid_o && !m_ready_i) stall_cnt++;
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) chk("underrun", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("data", m_data_o, e);
                end
                chk("last",     m_last_o, (beats + 1) == exp_len);
                chk("len_hold", m_len_o, exp_len - 1);
                if (beats == 0) first_beat_cyc = cyc;
                if (m_last_o) begin
                    last_beat_cyc = cyc; n_last++;
                    bursts.push_back(int'(m_len_o) + 1);
                end
                beats++; acc_total++;
            end
            if (!m_busy && c != 0) idle_run++; else idle_run = 0;
            if (c != 0 && p_c == 0) nz_cyc = cyc;
            if (flush_i && !p_f) flush_cyc = cyc;
            p_ok = 1;
        end
        p_c = c; p_f = flush_i; p_v = m_valid_o; p_rdy = m_ready_i;
        p_l = m_last_o; p_d = m_data_o; p_len = m_len_o; p_b = busy_o;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        tick();
        while ((busy_o || fifo_counter_i != '0) && n < budget) begin
            tick(); n++;
        end
        chk("idle_reached", n < budget, 1);
        repeat (2) tick();
    endtask

    task automatic chk_bursts(input string tag, input int n, input int l0, input int l1, input int l2);
        int exp_l[3];
        exp_l = '{l0, l1, l2};
        chk({tag, "_nbursts"}, bursts.size(), n);
        for (int i = 0; i < n && i < bursts.size(); i++) chk({tag, "_blen"}, bursts[i], exp_l[i]);
    endtask

    initial begin
        int n, acc0, pop0, last0, st0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Full burst, ready held high
        bursts.delete(); last0 = n_last;
        for (int i = 0; i < 8; i++) push_word(32'h10 + i);
        wait_idle(200);
        chk_bursts("t1", 1, 8, 0, 0);
        chk("t1_lat",   first_beat_cyc - rise_cyc, 1);
        chk("t1_span",  last_beat_cyc - first_beat_cyc, 7);
        chk("t1_nlast", n_last - last0, 1);
        chk("t1_valid", m_valid_o, 0);

        // Partial burst released by the idle timeout
        bursts.delete();
        for (int i = 0; i < 3; i++) push_word(32'h100 + i);
        wait_idle(300);
        chk_bursts("t2", 1, 3, 0, 0);
        chk("t2_start", rise_cyc - nz_cyc, TO);
        chk("t2_span",  last_beat_cyc - first_beat_cyc, 2);

        // Partial burst released by flush
        bursts.delete();
        for (int i = 0; i < 5; i++) push_word(32'h200 + i);
        tick();
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        wait_idle(100);
        chk_bursts("t3", 1, 5, 0, 0);
        chk("t3_first", first_beat_cyc - flush_cyc, 2);
        chk("t3_empty", fifo_empty_i, 1);

        // Backpressure pattern 1,0,0,1
        bursts.delete(); st0 = stall_cnt;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) push_word(32'h300 + i);
        wait_idle(400);
        rdy_mode = 0;
        chk_bursts("t4", 1, 8, 0, 0);
        chk("t4_stalled", (stall_cnt - st0) > 0, 1);

        // 20 words: 8, 8, then 4 on timeout
        bursts.delete(); last0 = n_last;
        for (int i = 0; i < 20; i++) push_word(32'h400 + i);
        wait_idle(500);
        chk_bursts("t5", 3, 8, 8, 4);
        chk("t5_nlast", n_last - last0, 3);
        chk("t5_count", fifo_counter_i, 0);

        // Reset after the third beat of a burst
        acc0 = acc_total;
        for (int i = 0; i < 8; i++) push_word(32'h500 + i);
        n = 0;
        while (acc_total - acc0 < 3 && n < 100) begin tick(); n++; end
        chk("t6_reach", n < 100, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_valid", m_valid_o, 0);
        chk("t6_busy",  busy_o, 0);
        pop0 = pop_total;
        repeat (20) tick();
        chk("t6_nopop", pop_total - pop0, 0);
        bursts.delete();
        for (int i = 0; i < 8; i++) push_word(32'h600 + i);
        wait_idle(200);
        chk_bursts("t6", 1, 8, 0, 0);

        // Randomized traffic
        rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            wr_en   = (fq.size() < 28) && ($urandom_range(0, 2) != 0);
            wr_data = $urandom;
            flush_i = ($urandom_range(0, 19) == 0);
            tick();
        end
        wr_en = 1'b0; flush_i = 1'b0; rdy_mode = 0;
        wait_idle(500);
        chk("t7_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
